// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver feeding a downstream FIFO, with sticky framing
//            and overrun flags and a written-byte counter.
//            Optional even-parity bit when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_SIZE     = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                fifo_full,
  input  logic                err_clr,
  output logic                wr_en,
  output logic [7:0]          wr_data,
  output logic                frame_err,
  output logic                overrun,
`ifdef UART_RX_PARITY_EN
  output logic                parity_err,
`endif
  output logic [CNT_SIZE-1:0] byte_count
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Timer counts down to zero, so a load of N-1 expires N cycles later.
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state, next_state;
  logic            rx_meta, rx_s, rx_prev;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            timer_done, start_edge, stop_tick;
  logic            write_ok, frame_set, ovr_set, par_bad;

  assign timer_done = (timer == '0);
  // Falling-edge detect also gives break handling: after a low stop bit a new
  // start is only seen once rx_s has returned high.
  assign start_edge = rx_prev & ~rx_s;
  assign stop_tick  = (state == S_STOP) && timer_done;
  assign write_ok   = stop_tick & rx_s & ~fifo_full & ~par_bad;
  assign ovr_set    = stop_tick & rx_s & fifo_full & ~par_bad;
  assign frame_set  = stop_tick & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start_edge) next_state = S_START;
      S_START: if (timer_done) next_state = rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (timer_done && bit_idx == 3'd7) next_state = S_PARITY;
      S_PARITY: if (timer_done) next_state = S_STOP;
`else
      S_DATA:  if (timer_done && bit_idx == 3'd7) next_state = S_STOP;
`endif
      S_STOP:  if (timer_done) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (state == S_IDLE) begin
        if (start_edge) timer <= HALF_LOAD;
      end else if (timer_done) begin
        timer <= FULL_LOAD;
      end else begin
        timer <= timer - TW'(1);
      end
      if (state == S_START) bit_idx <= 3'd0;
      if (state == S_DATA && timer_done) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set;
  assign par_set = (state == S_PARITY) && timer_done && (^{shift, rx_s});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == S_START)  par_bad <= 1'b0;
      else if (par_set)      par_bad <= 1'b1;
      if (par_set)           parity_err <= 1'b1;
      else if (err_clr)      parity_err <= 1'b0;
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_data    <= 8'd0;
      byte_count <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_en <= write_ok;
      if (write_ok) begin
        wr_data    <= shift;
        byte_count <= byte_count + CNT_SIZE'(1);
      end
      // A set event in the same cycle as err_clr takes priority.
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ovr_set)      overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx at CLKS_PER_BIT=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int CW  = 18;

  logic          clk = 1'b0;
  logic          rst, rx, fifo_full, err_clr;
  logic          wr_en, frame_err, overrun;
  logic [7:0]    wr_data;
  logic [CW-1:0] byte_count;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_SIZE(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .fifo_full  (fifo_full),
    .err_clr    (err_clr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  int        n_pass  = 0;
  int        n_total = 0;
  int        cyc     = 0;
  int        last_wr_cyc = -1;
  int        start_cyc   = 0;
  logic      prev_wr = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the next expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        check("wr_en_not_consecutive", 32'(prev_wr), 32'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", wr_data);
        end else begin
          check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
        end
        last_wr_cyc = cyc;
      end
      prev_wr = wr_en;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic bit_time(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    start_cyc = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par_b);
`else
    if (par_b === 1'bx) $display("parity bit unknown");
`endif
    bit_time(stop_b);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_en",      32'(wr_en),      32'd0);
    check("rst_wr_data",    32'(wr_data),    32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_overrun",    32'(overrun),    32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; fifo_full = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    idle(5);

    // Single 0xA5 frame and its latency from the falling edge.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(5);
    check("a5_latency_ok", 32'((last_wr_cyc > start_cyc) && (last_wr_cyc - start_cyc <= 9*CPB + CPB/2 + 4)), 32'd1);
    check("a5_byte_count", 32'(byte_count), 32'd1);
    check("a5_frame_err",  32'(frame_err),  32'd0);
    check("a5_overrun",    32'(overrun),    32'd0);

    // Short low glitch is rejected silently.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    check("glitch_frame_err",  32'(frame_err),  32'd0);
    check("glitch_overrun",    32'(overrun),    32'd0);
    check("glitch_byte_count", 32'(byte_count), 32'd1);

    // Framing error, clear, then a clean frame.
    send_frame(8'h3C, 1'b0, ^8'h3C);
    idle(5);
    check("ferr_set",        32'(frame_err),  32'd1);
    check("ferr_byte_count", 32'(byte_count), 32'd1);
    pulse_clr();
    check("ferr_cleared", 32'(frame_err), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(5);
    check("3c_byte_count", 32'(byte_count), 32'd2);

    // Overrun with downstream FIFO full.
    fifo_full = 1'b1;
    send_frame(8'h55, 1'b1, ^8'h55);
    idle(5);
    check("ovr_set",        32'(overrun),    32'd1);
    check("ovr_byte_count", 32'(byte_count), 32'd2);
    check("ovr_frame_err",  32'(frame_err),  32'd0);
    fifo_full = 1'b0;
    pulse_clr();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // 256 back-to-back frames from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1, ^(8'(b)));
    end
    idle(2 * CPB);
    check("b2b_byte_count", 32'(byte_count), 32'd256);
    check("b2b_all_seen",   32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame discards it.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'(8'h99 >> i));
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(12 * CPB);
    check("midrst_byte_count", 32'(byte_count), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, ^8'h7E);
    idle(5);
    check("7e_byte_count", 32'(byte_count), 32'd1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b0);
    idle(5);
    check("par_err_set",    32'(parity_err), 32'd1);
    check("par_byte_count", 32'(byte_count), 32'd1);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(5);
    check("par_ok_count", 32'(byte_count), 32'd2);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 Parameter CNT_SIZE, default 18, width of byte_count.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8 data bits, LSB first.
REQ-006 fifo_full  input  1  full flag of downstream UART_FIFO.
REQ-007 err_clr  input  1  synchronous clear of sticky error flags.
REQ-008 wr_en  output  1  one-cycle write strobe into UART_FIFO.
REQ-009 wr_data  output  8  received byte, valid while wr_en=1.
REQ-010 frame_err  output  1  sticky; stop bit sampled low.
REQ-011 overrun  output  1  sticky; byte dropped because fifo_full=1.
REQ-012 byte_count  output  CNT_SIZE  bytes written to FIFO, wraps modulo 2^CNT_SIZE.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer (flops reset to 1) before any use; all timing below refers to synchronized rx (rx_s).
REQ-014 States SHALL be IDLE, START, DATA, STOP (plus PARITY when UART_RX_PARITY_EN defined), with one bit-timer of width clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-015 IDLE -> START on rx_s 1->0 transition; bit-timer loaded for CLKS_PER_BIT/2 (integer divide).
REQ-016 START: at timer expiry sample rx_s; 0 -> DATA with timer loaded CLKS_PER_BIT; 1 -> IDLE (glitch rejected, no flag).
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles into shift register, LSB first; after bit index 7 -> STOP (or PARITY).
REQ-018 STOP: sample rx_s after CLKS_PER_BIT cycles, then -> IDLE the same cycle.
REQ-019 Stop=1 and fifo_full=0 (sampled same cycle): wr_en=1 for exactly one cycle on the next cycle, wr_data=byte, byte_count increments same cycle as wr_en.
REQ-020 Stop=1 and fifo_full=1: no wr_en, overrun set to 1.
REQ-021 Stop=0: no wr_en, frame_err set to 1; IDLE SHALL not accept a new start until rx_s has been observed high (break handling).
REQ-022 wr_data SHALL hold its last value when wr_en=0; wr_en never asserted two consecutive cycles.
REQ-023 err_clr=1 clears frame_err/overrun (and parity_err) next cycle; a set event in the same cycle wins over clear.
REQ-024 Back-to-back frames (stop followed immediately by start) SHALL be received without loss.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, wr_en=0, wr_data=0, frame_err=0, overrun=0, byte_count=0, synchronizer flops=1, timer and bit index=0.
REQ-026 Reset mid-frame SHALL discard the partial byte; no wr_en is produced for it after rst deasserts.

Configuration
REQ-027 Macro UART_RX_PARITY_EN: when defined, a PARITY state after DATA samples one even-parity bit; mismatch sets sticky output parity_err (1 bit) and suppresses wr_en for that byte; frame then continues to STOP.
REQ-028 Without UART_RX_PARITY_EN: no PARITY state, no parity_err port, frame is 10 bits.

Verification (CLKS_PER_BIT=16, parity disabled unless noted)
REQ-029 Send 0xA5 with valid stop, fifo_full=0 -> exactly one wr_en, wr_data=0xA5, byte_count=1, within 9.5*16+4 cycles of the rx falling edge.
REQ-030 rx low pulse of 4 cycles, then idle -> no wr_en, no error flags, state back to IDLE.
REQ-031 Send 0x3C with stop bit 0 -> frame_err=1, no wr_en; err_clr pulse -> frame_err=0; next 0x3C received correctly.
REQ-032 Hold fifo_full=1, send 0x55 -> overrun=1, no wr_en, byte_count unchanged.
REQ-033 256 back-to-back frames 0x00..0xFF -> 256 wr_en pulses in order, byte_count=256; rst asserted mid-frame of a further byte -> all outputs 0, no write, subsequent 0x7E received.
REQ-034 With UART_RX_PARITY_EN, send 0x01 with parity bit 0 -> parity_err=1, no wr_en; with parity bit 1 -> wr_data=0x01.
